// File: rtl/btb_update_writer.sv
`default_nettype none
// ============================================================================
// Module   : btb_update_writer
// Purpose  : BTB write-port controller. It takes resolved branches from EX,
//            updates or allocates entries, and sweeps the valid bits after
//            reset or on a flush request.
// Options  : BTB_EVICT_ON_ZERO_EN - when defined, a hit update whose counter
//            falls to 00 writes the entry back as invalid.
// Revision : 1.0 - initial release
// ============================================================================
module btb_update_writer #(
    parameter int ENTRIES = 8,
    parameter int IDX_W   = 3,
    parameter int TAG_W   = 11
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             Upd_Valid,
    output logic             Upd_Ready,
    input  logic [31:0]      Upd_PC,
    input  logic [31:0]      Upd_Target,
    input  logic             Upd_Taken,
    input  logic             Upd_Hit,
    input  logic [IDX_W-1:0] Upd_Hit_Index,
    input  logic [1:0]       Upd_Cnt,
    input  logic             Flush_Req,
    input  logic             Port_Busy,
    output logic             Wr_En,
    output logic [IDX_W-1:0] Wr_Index,
    output logic [TAG_W-1:0] Wr_Tag,
    output logic [31:0]      Wr_Target,
    output logic [1:0]       Wr_Cnt,
    output logic             Wr_Valid,
    output logic             Flushing
);

    localparam logic [0:0]       c_ST_FLUSH = 1'b0;
    localparam logic [0:0]       c_ST_IDLE  = 1'b1;
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(ENTRIES - 1);
    localparam logic [IDX_W-1:0] c_IDX_ONE  = IDX_W'(1);

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [IDX_W-1:0] r_sweep;
    logic [IDX_W-1:0] w_sweep_nxt;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_ptr_nxt;
    logic             r_buf_v;
    logic             w_buf_v_nxt;
    logic [TAG_W-1:0] r_buf_tag;
    logic [31:0]      r_buf_target;
    logic             r_buf_taken;
    logic             r_buf_hit;
    logic [IDX_W-1:0] r_buf_idx;
    logic [1:0]       r_buf_cnt;
    logic             w_capture;
    logic [1:0]       w_hit_cnt;
    logic             w_hit_valid;
    logic             w_unused_pc;

    assign w_unused_pc = ^{Upd_PC[31:TAG_W+2], Upd_PC[1:0]};

    // Records that neither hit nor were taken carry nothing worth writing.
    assign w_capture = Upd_Valid & Upd_Ready & (Upd_Hit | Upd_Taken);

    always_comb begin
        if (r_buf_taken) begin
            w_hit_cnt = (r_buf_cnt == 2'b11) ? 2'b11 : r_buf_cnt + 2'd1;
        end else begin
            w_hit_cnt = (r_buf_cnt == 2'b00) ? 2'b00 : r_buf_cnt - 2'd1;
        end
    end

`ifdef BTB_EVICT_ON_ZERO_EN
    assign w_hit_valid = (w_hit_cnt != 2'b00);
`else
    assign w_hit_valid = 1'b1;
`endif

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            r_state <= c_ST_FLUSH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            r_sweep <= '0;
            r_ptr   <= '0;
            r_buf_v <= 1'b0;
        end else begin
            r_sweep <= w_sweep_nxt;
            r_ptr   <= w_ptr_nxt;
            r_buf_v <= w_buf_v_nxt;
        end
    end

    always_ff @(posedge Clock) begin
        if (w_capture) begin
            r_buf_tag    <= Upd_PC[TAG_W+1:2];
            r_buf_target <= Upd_Target;
            r_buf_taken  <= Upd_Taken;
            r_buf_hit    <= Upd_Hit;
            r_buf_idx    <= Upd_Hit_Index;
            r_buf_cnt    <= Upd_Cnt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sweep_nxt = r_sweep;
        w_ptr_nxt   = r_ptr;
        w_buf_v_nxt = r_buf_v;
        if (Flush_Req) begin
            w_state_nxt = c_ST_FLUSH;
            w_sweep_nxt = '0;
            w_ptr_nxt   = '0;
            w_buf_v_nxt = 1'b0;
        end else if (r_state == c_ST_FLUSH) begin
            if (Wr_En) begin
                if (r_sweep == c_LAST_IDX) begin
                    w_state_nxt = c_ST_IDLE;
                    w_sweep_nxt = '0;
                end else begin
                    w_sweep_nxt = r_sweep + c_IDX_ONE;
                end
            end
        end else begin
            if (Wr_En) begin
                w_buf_v_nxt = 1'b0;
                if (!r_buf_hit) begin
                    w_ptr_nxt = r_ptr + c_IDX_ONE;
                end
            end
            if (w_capture) begin
                w_buf_v_nxt = 1'b1;
            end
        end
    end

    always_comb begin
        Upd_Ready = Reset_n & (r_state == c_ST_IDLE) & ~r_buf_v;
        Flushing  = Reset_n & (r_state == c_ST_FLUSH);
        Wr_En     = 1'b0;
        Wr_Index  = r_buf_idx;
        Wr_Tag    = r_buf_tag;
        Wr_Target = r_buf_target;
        Wr_Cnt    = w_hit_cnt;
        Wr_Valid  = w_hit_valid;
        if (r_state == c_ST_FLUSH) begin
            Wr_En     = Reset_n & ~Port_Busy;
            Wr_Index  = r_sweep;
            Wr_Tag    = '0;
            Wr_Target = '0;
            Wr_Cnt    = 2'b00;
            Wr_Valid  = 1'b0;
        end else begin
            // A flush in the same cycle wins over the buffered write.
            Wr_En = Reset_n & r_buf_v & ~Port_Busy & ~Flush_Req;
            if (!r_buf_hit) begin
                Wr_Index = r_ptr;
                Wr_Cnt   = 2'b10;
                Wr_Valid = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_btb_update_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_btb_update_writer
// Purpose  : Self-checking bench for btb_update_writer (vector table, directed
//            corner sequences and a randomized run against a reference model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_btb_update_writer;

    localparam int ENTRIES = 8;
    localparam int IDX_W   = 3;
    localparam int TAG_W   = 11;
`ifdef BTB_EVICT_ON_ZERO_EN
    localparam logic EVICT = 1'b1;
`else
    localparam logic EVICT = 1'b0;
`endif

    logic             Clock = 1'b0;
    logic             Reset_n;
    logic             Upd_Valid;
    logic             Upd_Ready;
    logic [31:0]      Upd_PC;
    logic [31:0]      Upd_Target;
    logic             Upd_Taken;
    logic             Upd_Hit;
    logic [IDX_W-1:0] Upd_Hit_Index;
    logic [1:0]       Upd_Cnt;
    logic             Flush_Req;
    logic             Port_Busy;
    logic             Wr_En;
    logic [IDX_W-1:0] Wr_Index;
    logic [TAG_W-1:0] Wr_Tag;
    logic [31:0]      Wr_Target;
    logic [1:0]       Wr_Cnt;
    logic             Wr_Valid;
    logic             Flushing;

    always #5 Clock = ~Clock;

    btb_update_writer #(.ENTRIES(ENTRIES), .IDX_W(IDX_W), .TAG_W(TAG_W)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .Upd_Valid(Upd_Valid), .Upd_Ready(Upd_Ready),
        .Upd_PC(Upd_PC), .Upd_Target(Upd_Target), .Upd_Taken(Upd_Taken), .Upd_Hit(Upd_Hit),
        .Upd_Hit_Index(Upd_Hit_Index), .Upd_Cnt(Upd_Cnt), .Flush_Req(Flush_Req),
        .Port_Busy(Port_Busy), .Wr_En(Wr_En), .Wr_Index(Wr_Index), .Wr_Tag(Wr_Tag),
        .Wr_Target(Wr_Target), .Wr_Cnt(Wr_Cnt), .Wr_Valid(Wr_Valid), .Flushing(Flushing)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        taken;
        logic        hit;
        logic [2:0]  hidx;
        logic [1:0]  cnt;
        logic        wen;
        logic [2:0]  idx;
        logic [10:0] tag;
        logic [1:0]  ecnt;
        logic        evalid;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        taken;
        logic        hit;
        logic [2:0]  hidx;
        logic [1:0]  cnt;
    } rec_t;

    vec_t vecs[9];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic present(input logic [31:0] pc, input logic [31:0] tgt, input logic tk,
                           input logic h, input logic [2:0] hi, input logic [1:0] c);
        Upd_Valid     = 1'b1;
        Upd_PC        = pc;
        Upd_Target    = tgt;
        Upd_Taken     = tk;
        Upd_Hit       = h;
        Upd_Hit_Index = hi;
        Upd_Cnt       = c;
    endtask

    task automatic run_flush_sweep(input string tag);
        for (int i = 0; i < ENTRIES; i++) begin
            #2;
            check({tag, "_wen"}, Wr_En, 1);
            check({tag, "_idx"}, Wr_Index, i);
            check({tag, "_valid"}, Wr_Valid, 0);
            check({tag, "_flushing"}, Flushing, 1);
            check({tag, "_ready"}, Upd_Ready, 0);
            step();
        end
        #2;
        check({tag, "_ready_after"}, Upd_Ready, 1);
        check({tag, "_flushing_after"}, Flushing, 0);
    endtask

    initial begin
        rec_t        q[$];
        rec_t        r;
        logic        m_flushing;
        int          m_sweep;
        int          m_ptr;
        logic        busy;
        logic        flush;
        logic        exp_ready;
        logic        exp_wen;
        int          nc;

        vecs[0] = '{32'h00400024, 32'h00400100, 1'b1, 1'b0, 3'd0, 2'd0, 1'b1, 3'd0, 11'h009, 2'd2, 1'b1};
        vecs[1] = '{32'h00400040, 32'h00400200, 1'b1, 1'b0, 3'd0, 2'd0, 1'b1, 3'd1, 11'h010, 2'd2, 1'b1};
        vecs[2] = '{32'h00401234, 32'h00402000, 1'b1, 1'b1, 3'd5, 2'd3, 1'b1, 3'd5, 11'h48D, 2'd3, 1'b1};
        vecs[3] = '{32'h00401234, 32'h00402000, 1'b0, 1'b1, 3'd5, 2'd1, 1'b1, 3'd5, 11'h48D, 2'd0, !EVICT};
        vecs[4] = '{32'h00400050, 32'h00000000, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 3'd0, 11'h000, 2'd0, 1'b0};
        vecs[5] = '{32'h0000FFFC, 32'h12345678, 1'b0, 1'b1, 3'd2, 2'd0, 1'b1, 3'd2, 11'h7FF, 2'd0, !EVICT};
        vecs[6] = '{32'h80000008, 32'hDEADBEEC, 1'b1, 1'b1, 3'd7, 2'd2, 1'b1, 3'd7, 11'h002, 2'd3, 1'b1};
        vecs[7] = '{32'h00400060, 32'h00400300, 1'b0, 1'b1, 3'd3, 2'd2, 1'b1, 3'd3, 11'h018, 2'd1, 1'b1};
        vecs[8] = '{32'h00000FFC, 32'h00000004, 1'b1, 1'b0, 3'd6, 2'd1, 1'b1, 3'd2, 11'h3FF, 2'd2, 1'b1};

        Reset_n = 1'b0; Flush_Req = 1'b0; Port_Busy = 1'b0;
        present(0, 0, 0, 0, 0, 0);
        Upd_Valid = 1'b0;

        // Reset held for two cycles.
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_ready", Upd_Ready, 0);
            check("rst_wen", Wr_En, 0);
            check("rst_flushing", Flushing, 0);
        end
        Reset_n = 1'b1;
        run_flush_sweep("init_flush");

        // Vector table: present, then check the write one cycle later.
        for (int i = 0; i < 9; i++) begin
            check("tbl_ready", Upd_Ready, 1);
            present(vecs[i].pc, vecs[i].tgt, vecs[i].taken, vecs[i].hit, vecs[i].hidx, vecs[i].cnt);
            #2;
            check("tbl_no_wen_on_accept", Wr_En, 0);
            step();
            Upd_Valid = 1'b0;
            #2;
            check("tbl_wen", Wr_En, vecs[i].wen);
            if (vecs[i].wen) begin
                check("tbl_idx", Wr_Index, vecs[i].idx);
                check("tbl_tag", Wr_Tag, vecs[i].tag);
                check("tbl_target", Wr_Target, vecs[i].tgt);
                check("tbl_cnt", Wr_Cnt, vecs[i].ecnt);
                check("tbl_valid", Wr_Valid, vecs[i].evalid);
            end else begin
                check("tbl_ready_after_drop", Upd_Ready, 1);
            end
            step();
        end

        // Allocations continue from index 3; the ninth allocation wraps to 0.
        for (int k = 0; k < 6; k++) begin
            present(32'h00500000 + 32'(k * 4), 32'h00600000, 1'b1, 1'b0, 3'd0, 2'd0);
            step();
            Upd_Valid = 1'b0;
            #2;
            check("wrap_wen", Wr_En, 1);
            check("wrap_idx", Wr_Index, (3 + k) % ENTRIES);
            step();
        end

        // Port busy for three cycles holds the buffered record.
        present(32'h00400070, 32'h00400444, 1'b1, 1'b0, 3'd0, 2'd0);
        step();
        Upd_Valid = 1'b0;
        Port_Busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2;
            check("busy_wen", Wr_En, 0);
            check("busy_ready", Upd_Ready, 0);
            step();
        end
        Port_Busy = 1'b0;
        #2;
        check("busy_release_wen", Wr_En, 1);
        check("busy_release_idx", Wr_Index, 1);
        check("busy_release_tag", Wr_Tag, 11'h01C);
        check("busy_release_target", Wr_Target, 32'h00400444);
        check("busy_release_cnt", Wr_Cnt, 2);
        step();

        // Flush while a record is buffered: the record is never written.
        present(32'h00400080, 32'h00400888, 1'b1, 1'b0, 3'd0, 2'd0);
        step();
        Upd_Valid = 1'b0;
        Flush_Req = 1'b1;
        #2;
        check("flushreq_suppress_wen", Wr_En, 0);
        step();
        Flush_Req = 1'b0;
        run_flush_sweep("req_flush");
        present(32'h00400090, 32'h00400999, 1'b1, 1'b0, 3'd0, 2'd0);
        step();
        Upd_Valid = 1'b0;
        #2;
        check("post_flush_alloc_wen", Wr_En, 1);
        check("post_flush_alloc_idx", Wr_Index, 0);
        step();

        // Randomized run against a transaction-level model.
        m_flushing = 1'b0;
        m_sweep    = 0;
        m_ptr      = 1;
        for (int k = 0; k < 600; k++) begin
            Upd_Valid     = 1'($urandom_range(0, 1));
            Upd_PC        = $urandom;
            Upd_Target    = $urandom;
            Upd_Taken     = 1'($urandom_range(0, 1));
            Upd_Hit       = 1'($urandom_range(0, 1));
            Upd_Hit_Index = 3'($urandom_range(0, 7));
            Upd_Cnt       = 2'($urandom_range(0, 3));
            busy          = ($urandom_range(0, 3) == 0);
            flush         = (k == 0) || ($urandom_range(0, 59) == 0);
            Port_Busy     = busy;
            Flush_Req     = flush;
            #2;
            exp_ready = !m_flushing && (q.size() == 0);
            check("rnd_ready", Upd_Ready, exp_ready);
            check("rnd_flushing", Flushing, m_flushing);
            if (m_flushing) begin
                exp_wen = !busy;
                if (exp_wen) begin
                    check("rnd_sweep_idx", Wr_Index, m_sweep);
                    check("rnd_sweep_valid", Wr_Valid, 0);
                end
            end else if (q.size() != 0 && !busy && !flush) begin
                exp_wen = 1'b1;
                r = q[0];
                if (r.hit) begin
                    nc = r.taken ? int'(r.cnt) + 1 : int'(r.cnt) - 1;
                    if (nc > 3) nc = 3;
                    if (nc < 0) nc = 0;
                    check("rnd_hit_idx", Wr_Index, r.hidx);
                    check("rnd_hit_cnt", Wr_Cnt, nc);
                    check("rnd_hit_valid", Wr_Valid, (EVICT && nc == 0) ? 0 : 1);
                end else begin
                    check("rnd_alloc_idx", Wr_Index, m_ptr);
                    check("rnd_alloc_cnt", Wr_Cnt, 2);
                    check("rnd_alloc_valid", Wr_Valid, 1);
                end
                check("rnd_tag", Wr_Tag, r.pc[TAG_W+1:2]);
                check("rnd_target", Wr_Target, r.tgt);
            end else begin
                exp_wen = 1'b0;
            end
            check("rnd_wen", Wr_En, exp_wen);

            if (flush) begin
                m_flushing = 1'b1;
                m_sweep    = 0;
                m_ptr      = 0;
                q.delete();
            end else if (m_flushing) begin
                if (!busy) begin
                    if (m_sweep == ENTRIES - 1) begin
                        m_flushing = 1'b0;
                        m_sweep    = 0;
                    end else begin
                        m_sweep++;
                    end
                end
            end else begin
                if (exp_wen) begin
                    r = q.pop_front();
                    if (!r.hit) m_ptr = (m_ptr + 1) % ENTRIES;
                end
                if (exp_ready && Upd_Valid && (Upd_Hit || Upd_Taken)) begin
                    r.pc    = Upd_PC;
                    r.tgt   = Upd_Target;
                    r.taken = Upd_Taken;
                    r.hit   = Upd_Hit;
                    r.hidx  = Upd_Hit_Index;
                    r.cnt   = Upd_Cnt;
                    q.push_back(r);
                end
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
